// File: rtl/biquad8_coeff_loader.sv
// Coefficient shadow RAM and shift/update sequencer for the incremental biquad B-cascade.
// Optional registered readback port enabled by defining BIQUAD_COEFF_READBACK_EN.
module biquad8_coeff_loader #(
    parameter int NSAMP = 8,
    localparam int NCOEFF = 2 * (NSAMP - 2),
    localparam int AW = $clog2(NCOEFF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [17:0]   wr_dat_i,
    input  logic          load_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [17:0]   rd_dat_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          wr_drop_o,
    output logic [17:0]   coeff_dat_o,
    output logic          coeff_wr_o,
    output logic          coeff_update_o
);

    localparam logic [AW:0] NCOEFF_W = (AW + 1)'(NCOEFF);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StUpdate
    } state_e;

    state_e        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [17:0]   dat_q, dat_d;
    logic          done_q, done_d;
    logic          drop_q, drop_d;
    logic [17:0]   shadow_q [NCOEFF];
    logic          wr_ok;
    logic [AW-1:0] shift_idx;

    assign wr_ok     = wr_i && (state_q == StIdle) && ({1'b0, wr_addr_i} < NCOEFF_W);
    assign shift_idx = AW'(cnt_q - 1'b1);

    // Shadow contents deliberately survive rst; rst only blocks a coincident write.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            shadow_q[wr_addr_i] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dat_q   <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dat_d          = '0;
        done_d         = 1'b0;
        drop_d         = wr_i && (state_q != StIdle);
        coeff_wr_o     = 1'b0;
        coeff_update_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_i) begin
                    state_d = StShift;
                    cnt_d   = NCOEFF_W;
                end
            end
            StShift: begin
                // Highest index goes out first; data is registered so it trails the strobe.
                if (cnt_q != '0) begin
                    coeff_wr_o = 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                    dat_d      = shadow_q[shift_idx];
                end else begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                coeff_update_o = 1'b1;
                done_d         = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign wr_drop_o   = drop_q;
    assign coeff_dat_o = dat_q;

`ifdef BIQUAD_COEFF_READBACK_EN
    logic [17:0] rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if ({1'b0, rd_addr_i} < NCOEFF_W) begin
            rd_q <= shadow_q[rd_addr_i];
        end else begin
            rd_q <= '0;
        end
    end

    assign rd_dat_o = rd_q;
`else
    logic unused_rd_addr;

    assign unused_rd_addr = ^rd_addr_i;
    assign rd_dat_o       = '0;
`endif

endmodule
